// File: rtl/regfile_wb_arbiter.sv
// Write-back merge stage in front of the register file write port: the pipeline always
// wins, long-latency returns share the rest round-robin, and a starvation counter asks for a freeze.
module regfile_wb_arbiter #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int num_src_p         = 3,
  parameter int stall_threshold_p = 4,
  parameter bit x0_tied_to_zero_p = 1'b1,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     pipe_v_i,
  input  logic [addr_width_lp-1:0]                 pipe_addr_i,
  input  logic [width_p-1:0]                       pipe_data_i,
  input  logic [num_src_p-1:0]                     src_v_i,
  input  logic [num_src_p-1:0][addr_width_lp-1:0]  src_addr_i,
  input  logic [num_src_p-1:0][width_p-1:0]        src_data_i,
  output logic [num_src_p-1:0]                     src_yumi_o,
  output logic                                     w_v_o,
  output logic [addr_width_lp-1:0]                 w_addr_o,
  output logic [width_p-1:0]                       w_data_o,
  output logic                                     clear_v_o,
  output logic [addr_width_lp-1:0]                 clear_addr_o,
  output logic                                     stall_pipe_o
);

  localparam int ptr_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int cnt_width_lp = (stall_threshold_p + 1 > 1) ? $clog2(stall_threshold_p + 1) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(stall_threshold_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(stall_threshold_p);
  localparam logic [ptr_width_lp:0]   num_src_lp  = (ptr_width_lp + 1)'(num_src_p);
  localparam logic [ptr_width_lp-1:0] last_src_lp = ptr_width_lp'(num_src_p - 1);

  typedef enum logic {
    e_run,
    e_freeze
  } state_e;

  state_e                  state_q, state_d;
  logic [ptr_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [cnt_width_lp-1:0] blk_cnt_q, blk_cnt_d;
  logic                    stall_pipe_q, stall_pipe_d;

  logic [ptr_width_lp:0]    scan_idx;
  logic                     src_found;
  logic [ptr_width_lp-1:0]  grant_idx;
  logic                     src_grant;
  logic                     blocked;
  logic [addr_width_lp-1:0] sel_addr;
  logic                     x0_hit;

  // Scan from the highest offset down so the source nearest rr_ptr is the last one kept.
  always_comb begin
    scan_idx  = '0;
    src_found = 1'b0;
    grant_idx = '0;
    for (int i = num_src_p - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr_q} + (ptr_width_lp + 1)'(i);
      if (scan_idx >= num_src_lp) begin
        scan_idx = scan_idx - num_src_lp;
      end
      if (src_v_i[scan_idx[ptr_width_lp-1:0]]) begin
        src_found = 1'b1;
        grant_idx = scan_idx[ptr_width_lp-1:0];
      end
    end
  end

  always_comb begin
    src_grant    = !reset_i && !pipe_v_i && src_found;
    blocked      = pipe_v_i && (|src_v_i);
    sel_addr     = pipe_v_i ? pipe_addr_i : src_addr_i[grant_idx];
    x0_hit       = x0_tied_to_zero_p && (sel_addr == '0);
    src_yumi_o   = '0;
    if (src_grant) begin
      src_yumi_o[grant_idx] = 1'b1;
    end
    w_v_o        = !reset_i && (pipe_v_i || src_found) && !x0_hit;
    w_addr_o     = sel_addr;
    w_data_o     = pipe_v_i ? pipe_data_i : src_data_i[grant_idx];
    clear_v_o    = src_grant;
    clear_addr_o = src_addr_i[grant_idx];
  end

  // A freeze lasts until a source actually retires, or until no source is left to retire.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    blk_cnt_d = blk_cnt_q;
    if (src_grant) begin
      rr_ptr_d = (grant_idx == last_src_lp) ? '0 : grant_idx + 1'b1;
    end
    unique case (state_q)
      e_run: begin
        if (!blocked) begin
          blk_cnt_d = '0;
        end else if (blk_cnt_q == cnt_last_lp) begin
          state_d   = e_freeze;
          blk_cnt_d = '0;
        end else if (blk_cnt_q != cnt_max_lp) begin
          blk_cnt_d = blk_cnt_q + 1'b1;
        end
      end
      e_freeze: begin
        blk_cnt_d = '0;
        if (src_grant || !(|src_v_i)) begin
          state_d = e_run;
        end
      end
      default: begin
        state_d   = e_run;
        blk_cnt_d = '0;
      end
    endcase
    stall_pipe_d = (state_d == e_freeze);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_run;
      rr_ptr_q     <= '0;
      blk_cnt_q    <= '0;
      stall_pipe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      blk_cnt_q    <= blk_cnt_d;
      stall_pipe_q <= stall_pipe_d;
    end
  end

  assign stall_pipe_o = stall_pipe_q;

`ifndef SYNTHESIS
  // The pipeline must stay quiet while a freeze is being requested.
  pipe_during_freeze_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_freeze) |-> !pipe_v_i);
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back merge stage directly upstream of the integer register file's single write port.
- Merges the in-order pipeline write-back with num_src_p long-latency return sources (remote load returns, divider, FPU-to-int moves) into one write per cycle.
- The pipeline write always has priority; long-latency sources are served round-robin.
- A starvation counter requests a one-shot pipeline freeze so returns cannot be blocked indefinitely. Retired long-latency writes are reported to the scoreboard.

Parameters:
- width_p, 32, data width of a register.
- els_p, 32, number of registers; addr_width_lp = `BSG_SAFE_CLOG2(els_p).
- num_src_p, 3, number of long-latency return sources (>=1).
- stall_threshold_p, 4, consecutive blocked cycles before a freeze is requested (>=1).
- x0_tied_to_zero_p, 1, if 1, writes to address 0 are consumed but not forwarded.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- pipe_v_i  in  1  pipeline write-back valid; no backpressure.
- pipe_addr_i  in  addr_width_lp  pipeline destination.
- pipe_data_i  in  width_p  pipeline data.
- src_v_i  in  num_src_p  long-latency source valid.
- src_addr_i  in  num_src_p x addr_width_lp  source destination.
- src_data_i  in  num_src_p x width_p  source data.
- src_yumi_o  out  num_src_p  one-hot; source consumed this cycle.
- w_v_o  out  1  register-file write enable.
- w_addr_o  out  addr_width_lp  register-file write address.
- w_data_o  out  width_p  register-file write data.
- clear_v_o  out  1  scoreboard clear for a retired long-latency write.
- clear_addr_o  out  addr_width_lp  address being cleared.
- stall_pipe_o  out  1  registered freeze request to the pipeline.

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Outputs during reset: src_yumi_o=0, w_v_o=0, clear_v_o=0, stall_pipe_o=0. Internal state: rr_ptr=0, blk_cnt=0, FSM=RUN.
- Grant logic is combinational with zero latency. The register file captures the write at the next edge.
- pipe_v_i=1: pipeline wins. w_* come from pipe_*, and src_yumi_o=0.
- pipe_v_i=0 and any src_v_i set: grant the first valid source scanning from rr_ptr upward with wrap. Set that bit of src_yumi_o, drive w_* from it, and drive clear_v_o=1 with clear_addr_o equal to the source address.
- On a source grant at index g, at the next edge rr_ptr <= (g+1) mod num_src_p. rr_ptr is unchanged otherwise.
- x0 filtering, when x0_tied_to_zero_p=1 and the selected address is 0:
  - w_v_o=0.
  - A source is still yumi'd.
  - clear_v_o still fires for source writes.
- src_v_i must stay stable until yumi. The block never yumis an invalid source.
- Starvation FSM, states RUN and FREEZE:
  - RUN: blk_cnt increments on each cycle where |src_v_i & pipe_v_i. It resets to 0 on any cycle with no blocked source, including a cycle with a source grant.
  - RUN to FREEZE: when blk_cnt == stall_threshold_p-1 and the current cycle is blocked. stall_pipe_o goes to 1 from the next cycle.
  - FREEZE: stall_pipe_o=1. The pipeline is required to hold pipe_v_i=0.
  - FREEZE to RUN: at the edge ending the first cycle with a source grant. stall_pipe_o drops the following cycle and blk_cnt=0.
  - If pipe_v_i=1 during FREEZE, the pipeline still wins and the FSM stays in FREEZE. A simulation-only assertion flags this protocol error.
  - If no source is valid in FREEZE, which can only happen through a protocol error, return to RUN.
- Simultaneous pipeline and source writes to the same address: the pipeline write lands and the source stays pending. The scoreboard prevents this hazard; the block does not reorder.
- Reset mid-FREEZE: stall_pipe_o=0 on the cycle after reset is sampled, and all state clears.
- blk_cnt width: `BSG_SAFE_CLOG2(stall_threshold_p+1). It saturates and never wraps.

Test Plan:
1. Pipeline only: pipe_v_i=1, addr 5, data 0xDEAD_BEEF, no sources -> w_v_o=1, w_addr_o=5, w_data_o=0xDEADBEEF, clear_v_o=0.
2. Round-robin: pipe_v_i=0, src_v_i=3'b111 held, each source re-presents after yumi -> yumi sequence 001, 010, 100, 001; clear_addr_o tracks each source's address.
3. Starvation, stall_threshold_p=4: src_v_i=3'b010 and pipe_v_i=1 for 4 cycles -> stall_pipe_o=1 from cycle 5. Bench drops pipe_v_i -> yumi=010 that cycle, stall_pipe_o=0 the next cycle.
4. x0 filtering: source 0 returns to addr 0, pipe_v_i=0 -> src_yumi_o=001, w_v_o=0, clear_v_o=1, clear_addr_o=0. Pipeline write to addr 0 -> w_v_o=0.
5. Reset in FREEZE: assert reset_i for 1 cycle while stall_pipe_o=1 -> stall_pipe_o=0, rr_ptr=0. Next grant with src_v_i=111 goes to source 0.
6. Block then idle: 3 blocked cycles, then 1 cycle with pipe_v_i=0 and src_v_i=0 -> blk_cnt resets. 3 more blocked cycles -> no stall_pipe_o.
